prog_loader: RTL and testbench

- Byte-stream program loader. Writes 9-bit instructions into the instruction memory that the microprocessor fetches from, so it is the writer for the CPU's instruction fetch.
- Holds the CPU in reset while it loads, checks a frame checksum, then releases the CPU to run from address 0.
- Sits between a host byte source and the instruction memory's write port, alongside the processor and its memories.

---
 rtl/prog_loader.sv | 194 +++++++++++++++++++
 tb/tb_prog_loader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//
// Byte-stream program loader for the microprocessor's instruction memory.
// A frame is: COUNT byte N (0 means 2**ADDR_WIDTH), then N LO/HI byte pairs
// each forming one instruction {HI, LO} truncated to INSTR_WIDTH bits, then a
// CHK byte equal to the XOR of every preceding frame byte. Each instruction is
// written through a one-cycle Prog_WE pulse at consecutive addresses from 0.
// The CPU is held in reset (Cpu_Rst=0) until a frame's checksum verifies.
//
// Parameters
//   ADDR_WIDTH   instruction memory address width (depth = 2**ADDR_WIDTH)
//   INSTR_WIDTH  instruction word width, 9..16
//
// Ports
//   Clk               system clock, rising edge
//   Rst               asynchronous active-low reset
//   Start             one-cycle pulse beginning a frame (ignored while Busy)
//   Byte_In           stream data byte
//   Byte_Valid        Byte_In valid this cycle
//   Byte_Ready        loader accepts a byte this cycle (transfer = Valid&Ready)
//   Prog_Address      instruction memory write address
//   Prog_Instruction  instruction memory write data
//   Prog_WE           instruction memory write enable, one-cycle pulse
//   Cpu_Rst           active-low reset to the microprocessor
//   Busy              a frame is in progress
//   Done              last frame loaded and verified
//   Error             last frame rejected
// -----------------------------------------------------------------------------
module prog_loader #(
    parameter int ADDR_WIDTH  = 8,
    parameter int INSTR_WIDTH = 9
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   Start,
    input  logic [7:0]             Byte_In,
    input  logic                   Byte_Valid,
    output logic                   Byte_Ready,
    output logic [ADDR_WIDTH-1:0]  Prog_Address,
    output logic [INSTR_WIDTH-1:0] Prog_Instruction,
    output logic                   Prog_WE,
    output logic                   Cpu_Rst,
    output logic                   Busy,
    output logic                   Done,
    output logic                   Error
);

    // Remaining-count width must hold both 2**ADDR_WIDTH and any 8-bit count.
    localparam int CNT_W = ((ADDR_WIDTH > 8) ? ADDR_WIDTH : 8) + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(1 << ADDR_WIDTH);
    localparam logic [CNT_W-1:0] ONE_COUNT  = CNT_W'(1);

    // HI-byte bits that fall outside the instruction word and must be zero.
    localparam logic [7:0] RSV_MASK = 8'(16'h00FF << (INSTR_WIDTH - 8));

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_LO,
        S_HI,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [CNT_W-1:0]      remaining;
    logic [7:0]            acc;
    logic [7:0]            lo_byte;
    logic                  xfer;
    logic                  hi_reserved;

    assign xfer        = Byte_Valid & Byte_Ready;
    assign hi_reserved = (Byte_In & RSV_MASK) != 8'd0;

    // State register
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (Start) next_state = S_COUNT;
            end
            S_COUNT: begin
                if (xfer) next_state = S_LO;
            end
            S_LO: begin
                if (xfer) next_state = S_HI;
            end
            S_HI: begin
                if (xfer) next_state = hi_reserved ? S_ERR : S_WRITE;
            end
            S_WRITE: begin
                // remaining still holds the pre-decrement value here
                next_state = (remaining == ONE_COUNT) ? S_CHECK : S_LO;
            end
            S_CHECK: begin
                if (xfer) next_state = (Byte_In == acc) ? S_DONE : S_ERR;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        Byte_Ready = 1'b0;
        Prog_WE    = 1'b0;
        Busy       = 1'b0;
        Done       = 1'b0;
        Error      = 1'b0;
        Cpu_Rst    = 1'b0;
        case (state)
            S_COUNT, S_LO, S_HI, S_CHECK: begin
                Byte_Ready = 1'b1;
                Busy       = 1'b1;
            end
            S_WRITE: begin
                Prog_WE = 1'b1;
                Busy    = 1'b1;
            end
            S_DONE: begin
                Done    = 1'b1;
                Cpu_Rst = 1'b1;
            end
            S_ERR: begin
                Error = 1'b1;
            end
            default: ;
        endcase
    end

    // Frame datapath: address/remaining counters, checksum, write port regs.
    // The write port registers load on the HI transfer so they are valid for
    // the WRITE cycle and then hold while the address counter moves on.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            addr             <= '0;
            remaining        <= '0;
            acc              <= '0;
            lo_byte          <= '0;
            Prog_Address     <= '0;
            Prog_Instruction <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (Start) begin
                        addr      <= '0;
                        remaining <= '0;
                        acc       <= '0;
                    end
                end
                S_COUNT: begin
                    if (xfer) begin
                        remaining <= (Byte_In == 8'd0) ? FULL_COUNT : CNT_W'(Byte_In);
                        acc       <= acc ^ Byte_In;
                    end
                end
                S_LO: begin
                    if (xfer) begin
                        lo_byte <= Byte_In;
                        acc     <= acc ^ Byte_In;
                    end
                end
                S_HI: begin
                    if (xfer) begin
                        acc <= acc ^ Byte_In;
                        if (!hi_reserved) begin
                            Prog_Address     <= addr;
                            Prog_Instruction <= INSTR_WIDTH'({Byte_In, lo_byte});
                        end
                    end
                end
                S_WRITE: begin
                    addr      <= addr + ADDR_WIDTH'(1);
                    remaining <= remaining - ONE_COUNT;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

    localparam int AW = 8;
    localparam int IW = 9;

    logic          Clk = 1'b0;
    logic          Rst = 1'b0;
    logic          Start = 1'b0;
    logic [7:0]    Byte_In = 8'h00;
    logic          Byte_Valid = 1'b0;
    logic          Byte_Ready;
    logic [AW-1:0] Prog_Address;
    logic [IW-1:0] Prog_Instruction;
    logic          Prog_WE;
    logic          Cpu_Rst;
    logic          Busy;
    logic          Done;
    logic          Error;

    prog_loader #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) dut (
        .Clk              (Clk),
        .Rst              (Rst),
        .Start            (Start),
        .Byte_In          (Byte_In),
        .Byte_Valid       (Byte_Valid),
        .Byte_Ready       (Byte_Ready),
        .Prog_Address     (Prog_Address),
        .Prog_Instruction (Prog_Instruction),
        .Prog_WE          (Prog_WE),
        .Cpu_Rst          (Cpu_Rst),
        .Busy             (Busy),
        .Done             (Done),
        .Error            (Error)
    );

    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [IW-1:0] instr;
    } wr_t;

    wr_t        sb[$];
    logic [7:0] frame_q[$];
    int         writes_seen = 0;
    logic       prev_we = 1'b0;
    int         gap_max = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Write monitor: every Prog_WE pulse is matched against the scoreboard.
    always @(negedge Clk) begin : wr_monitor
        wr_t e;
        if (Prog_WE) begin
            writes_seen++;
            check("wr_ready_low", 32'(Byte_Ready), 32'd0);
            check("wr_we_single", 32'(prev_we), 32'd0);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write required",
                         Prog_Address, Prog_Instruction);
            end else begin
                e = sb.pop_front();
                check("wr_addr", 32'(Prog_Address), 32'(e.addr));
                check("wr_data", 32'(Prog_Instruction), 32'(e.instr));
            end
        end
        prev_we = Prog_WE;
    end

    // Drive one byte with optional random idle cycles first; returns at the
    // falling edge after the byte was taken.
    task automatic send_byte(input logic [7:0] b);
        int n;
        if (gap_max > 0) begin
            n = int'($urandom_range(gap_max, 0));
            repeat (n) begin
                Byte_Valid = 1'b0;
                Byte_In    = 8'($urandom);
                @(negedge Clk);
            end
        end
        Byte_In    = b;
        Byte_Valid = 1'b1;
        n = 0;
        while (!Byte_Ready && n < 100) begin
            @(negedge Clk);
            n++;
        end
        if (!Byte_Ready) begin
            checks++;
            failures++;
            $display("FAIL byte_accept_timeout: byte 0x%0h not taken after %0d cycles, required acceptance", b, n);
        end else begin
            @(negedge Clk);
        end
        Byte_Valid = 1'b0;
    endtask

    task automatic start_pulse();
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    // Send frame_q; the reference parser pushes each expected write before
    // its HI byte goes out. start_at>=0 pulses Start before that byte.
    task automatic run_frame(input int start_at);
        int         cnt;
        logic [7:0] lo;
        logic [7:0] b;
        lo  = 8'h00;
        cnt = (frame_q[0] == 8'h00) ? 256 : int'(frame_q[0]);
        for (int i = 0; i < frame_q.size(); i++) begin
            b = frame_q[i];
            if (i == start_at) start_pulse();
            if (i >= 1 && i <= 2 * cnt) begin
                if (i % 2 == 1) lo = b;
                else if ((b & 8'hFE) == 8'h00)
                    sb.push_back(wr_t'({8'(i / 2 - 1), b[0], lo}));
            end
            send_byte(b);
        end
    endtask

    task automatic check_end(input logic exp_done, input logic exp_err, input int exp_writes, input int w0);
        check("end_done",    32'(Done),       32'(exp_done));
        check("end_error",   32'(Error),      32'(exp_err));
        check("end_cpu_rst", 32'(Cpu_Rst),    32'(exp_done));
        check("end_busy",    32'(Busy),       32'd0);
        check("end_ready",   32'(Byte_Ready), 32'd0);
        check("end_writes",  32'(writes_seen - w0), 32'(exp_writes));
        check("end_pending", 32'(sb.size()),  32'd0);
    endtask

    typedef struct packed {
        logic [7:0]  nbytes;
        logic [63:0] bytes;
        logic        exp_done;
        logic        exp_err;
        logic [7:0]  exp_writes;
    } vec_t;

    vec_t vecs [0:5];

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin : main
        int         w0;
        logic [7:0] chk;
        logic [7:0] lo;
        logic [7:0] hi;

        vecs[0] = '{8'd6, 64'h02A50103_00A50000, 1'b1, 1'b0, 8'd2}; // good frame
        vecs[1] = '{8'd6, 64'h02A50103_00000000, 1'b0, 1'b1, 8'd2}; // bad CHK
        vecs[2] = '{8'd3, 64'h01550200_00000000, 1'b0, 1'b1, 8'd0}; // reserved bit 1
        vecs[3] = '{8'd4, 64'h01FF01FF_00000000, 1'b1, 1'b0, 8'd1}; // N=1, 0x1FF
        vecs[4] = '{8'd8, 64'h03000000_01AB00A9, 1'b1, 1'b0, 8'd3}; // N=3
        vecs[5] = '{8'd5, 64'h02110022_80000000, 1'b0, 1'b1, 8'd1}; // reserved bit 7

        // Reset state
        repeat (3) @(negedge Clk);
        check("rst_ready", 32'(Byte_Ready),       32'd0);
        check("rst_we",    32'(Prog_WE),          32'd0);
        check("rst_busy",  32'(Busy),             32'd0);
        check("rst_done",  32'(Done),             32'd0);
        check("rst_error", 32'(Error),            32'd0);
        check("rst_cpu",   32'(Cpu_Rst),          32'd0);
        check("rst_addr",  32'(Prog_Address),     32'd0);
        check("rst_instr", 32'(Prog_Instruction), 32'd0);
        Rst = 1'b1;
        @(negedge Clk);

        // Table-driven frames
        for (int v = 0; v < 6; v++) begin
            gap_max = v % 2 * 2;
            frame_q.delete();
            for (int i = 0; i < int'(vecs[v].nbytes); i++)
                frame_q.push_back(vecs[v].bytes[63 - 8 * i -: 8]);
            start_pulse();
            check("frame_busy",    32'(Busy),    32'd1);
            check("frame_cpu_rst", 32'(Cpu_Rst), 32'd0);
            check("frame_done_clr", 32'(Done | Error), 32'd0);
            w0 = writes_seen;
            run_frame(-1);
            check_end(vecs[v].exp_done, vecs[v].exp_err, int'(vecs[v].exp_writes), w0);
            repeat (2) @(negedge Clk);
        end

        // N=0: 256 random words, random Byte_Valid gaps, address wrap
        gap_max = 2;
        frame_q.delete();
        frame_q.push_back(8'h00);
        chk = 8'h00;
        for (int k = 0; k < 256; k++) begin
            lo = 8'($urandom);
            hi = 8'($urandom_range(1, 0));
            frame_q.push_back(lo);
            frame_q.push_back(hi);
            chk = chk ^ lo ^ hi;
        end
        frame_q.push_back(chk);
        start_pulse();
        w0 = writes_seen;
        run_frame(-1);
        check_end(1'b1, 1'b0, 256, w0);
        check("n0_last_addr", 32'(Prog_Address), 32'd255);

        // Start pulsed mid-frame after 3 bytes is ignored
        gap_max = 0;
        frame_q = '{8'h02, 8'hA5, 8'h01, 8'h03, 8'h00, 8'hA5};
        start_pulse();
        w0 = writes_seen;
        run_frame(3);
        check_end(1'b1, 1'b0, 2, w0);

        // Asynchronous reset mid-frame, then a full frame
        frame_q = '{8'h02, 8'hA5, 8'h01};
        start_pulse();
        run_frame(-1);
        @(negedge Clk);
        #2 Rst = 1'b0;
        #1;
        check("arst_ready", 32'(Byte_Ready),       32'd0);
        check("arst_we",    32'(Prog_WE),          32'd0);
        check("arst_busy",  32'(Busy),             32'd0);
        check("arst_done",  32'(Done),             32'd0);
        check("arst_error", 32'(Error),            32'd0);
        check("arst_cpu",   32'(Cpu_Rst),          32'd0);
        check("arst_addr",  32'(Prog_Address),     32'd0);
        check("arst_instr", 32'(Prog_Instruction), 32'd0);
        check("arst_pending", 32'(sb.size()),      32'd0);
        @(negedge Clk);
        Rst = 1'b1;
        // Bytes offered in IDLE are dropped
        Byte_In    = 8'h55;
        Byte_Valid = 1'b1;
        repeat (3) @(negedge Clk);
        check("idle_ready", 32'(Byte_Ready), 32'd0);
        check("idle_busy",  32'(Busy),       32'd0);
        Byte_Valid = 1'b0;
        frame_q = '{8'h02, 8'hA5, 8'h01, 8'h03, 8'h00, 8'hA5};
        start_pulse();
        w0 = writes_seen;
        run_frame(-1);
        check_end(1'b1, 1'b0, 2, w0);

        repeat (2) @(negedge Clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
